// File: rtl/shared_ram_responder.sv
// ---------------------------------------------------------------------------
// shared_ram_responder
//
// This is the responder side of the processing-element memory interface. It
// owns one word-addressed RAM of 32-bit words and serves load and store
// requests from CORE_COUNT PE cores. It performs one access per cycle and
// returns the response exactly one cycle after the request is accepted.
//
// Configuration macro:
//   SHARED_RAM_RR_EN  defined   -> round-robin arbitration. The search
//                                  starts at the core after last_grant.
//                     undefined -> fixed priority. The lowest requesting
//                                  index wins.
//
// Parameters:
//   CORE_COUNT  number of requesting PE ports (1..16)
//   RAM_SIZE    RAM depth in 32-bit words
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   req_valid  per-core request valid
//   req_we     per-core write enable (1 = store, 0 = load)
//   req_addr   per-core word address; core i is at bits [32i+31:32i]
//   req_wdata  per-core store data, packed the same way
//   req_ready  one-hot grant. It is combinational, and the request is
//              accepted this cycle.
//   rsp_valid  one-hot response strobe for the core accepted last cycle
//   rsp_rdata  load data shared by all cores; 0 for stores and errors
//   rsp_err    the access accepted last cycle was out of range
// ---------------------------------------------------------------------------
module shared_ram_responder #(
    parameter int CORE_COUNT = 4,
    parameter int RAM_SIZE   = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CORE_COUNT-1:0]   req_valid,
    input  logic [CORE_COUNT-1:0]   req_we,
    input  logic [32*CORE_COUNT-1:0] req_addr,
    input  logic [32*CORE_COUNT-1:0] req_wdata,
    output logic [CORE_COUNT-1:0]   req_ready,
    output logic [CORE_COUNT-1:0]   rsp_valid,
    output logic [31:0]             rsp_rdata,
    output logic                    rsp_err
);

    localparam int GW = (CORE_COUNT > 1) ? $clog2(CORE_COUNT) : 1;
    localparam int AW = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;
    localparam logic [GW-1:0] LAST_GRANT_RST = GW'(CORE_COUNT - 1);

    // Unpacked views of the packed per-core buses. They let the core chosen
    // by arbitration be selected with a plain array index.
    logic [31:0] addr_arr  [CORE_COUNT];
    logic [31:0] wdata_arr [CORE_COUNT];

    for (genvar i = 0; i < CORE_COUNT; i++) begin : g_unpack
        assign addr_arr[i]  = req_addr[32*i +: 32];
        assign wdata_arr[i] = req_wdata[32*i +: 32];
    end

    logic [31:0]   mem [RAM_SIZE];
    logic [GW-1:0] last_grant;
    logic [GW-1:0] grant_idx;
    logic [GW-1:0] cand_idx;
    logic          grant_found;
    logic          accept;
    logic          sel_we;
    logic          sel_in_range;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic [AW-1:0] sel_idx;

    // -----------------------------------------------------------------------
    // Arbitration: pick at most one requesting core.
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable assigned in this block gets a default first.
        // Without the defaults, a path that leaves a variable unassigned
        // would make the tool infer a latch.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
`ifdef SHARED_RAM_RR_EN
        // Start searching at the core after the most recent grant and wrap
        // modulo CORE_COUNT. That makes last_grant the lowest priority.
        for (int off = 1; off <= CORE_COUNT; off++) begin
            cand_idx = GW'((int'(last_grant) + off) % CORE_COUNT);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
`else
        // Fixed priority: the lowest requesting index always wins.
        for (int i = 0; i < CORE_COUNT; i++) begin
            cand_idx = GW'(i);
            if (!grant_found && req_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
`endif
    end

    // No grant is issued while reset is held. This means an access that
    // lines up with the edge on which reset is released is never performed.
    assign accept = grant_found & ~rst;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // -----------------------------------------------------------------------
    // The winning request. The range check uses the full 32-bit address, so
    // an out-of-range address never aliases onto a valid word.
    // -----------------------------------------------------------------------
    assign sel_we       = req_we[grant_idx];
    assign sel_addr     = addr_arr[grant_idx];
    assign sel_wdata    = wdata_arr[grant_idx];
    assign sel_in_range = (sel_addr < 32'(RAM_SIZE));
    assign sel_idx      = sel_addr[AW-1:0];

    // -----------------------------------------------------------------------
    // RAM write port.
    // -----------------------------------------------------------------------
    // NOTE: the RAM array has no reset branch. Resetting it would turn the
    // storage into discrete flops. Contents written before a reset therefore
    // survive that reset.
    always_ff @(posedge clk) begin
        if (accept && sel_we && sel_in_range) begin
            mem[sel_idx] <= sel_wdata;
        end
    end

    // -----------------------------------------------------------------------
    // Response registers and arbitration state.
    // -----------------------------------------------------------------------
    // NOTE: state is updated with non-blocking assignments. All flops then
    // sample the values from before the edge, and a load accepted the cycle
    // after a store reads the freshly written word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_valid  <= '0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            last_grant <= LAST_GRANT_RST;
        end else begin
            rsp_valid <= req_ready;
            if (accept) begin
                last_grant <= grant_idx;
                rsp_err    <= ~sel_in_range;
                rsp_rdata  <= (!sel_we && sel_in_range) ? mem[sel_idx] : 32'h0;
            end else begin
                rsp_err   <= 1'b0;
                rsp_rdata <= 32'h0;
            end
        end
    end

    // The grant must be one-hot or zero. The arbitration pointer must always
    // name an existing core.
    a_ready_onehot0 : assert property (@(posedge clk) disable iff (rst)
        $onehot0(req_ready));
    a_last_grant_range : assert property (@(posedge clk) disable iff (rst)
        int'(last_grant) < CORE_COUNT);

endmodule
